// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset control unit.
// Holds opcode/funct codes, ALU operation codes, state encodings and mux selects.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd5;
    localparam logic [2:0] ALU_NOP  = 3'd7;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] WB_LUI    = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        AM_ADD   = 3'd0,
        AM_SUB   = 3'd1,
        AM_OR    = 3'd2,
        AM_NOP   = 3'd3,
        AM_FUNCT = 3'd4
    } alu_mode_t;

    // Per-state control word; the *_fetch and br_* bits are qualified by
    // mem_ready / zero outside the register so they can react in-cycle.
    typedef struct packed {
        logic       pc_wr_fetch;
        logic       ir_wr_fetch;
        logic       pc_wr_uncond;
        logic       br_eq;
        logic       br_ne;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
        logic       ext_op;
        alu_mode_t  alu_mode;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        c.alu_mode = AM_ADD;
        case (s)
            S_FETCH: begin
                c.mem_read    = 1'b1;
                c.alu_src_b   = SRCB_FOUR;
                c.pc_wr_fetch = 1'b1;
                c.ir_wr_fetch = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.ext_op    = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_mode  = AM_FUNCT;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RD;
                c.mem_to_reg = WB_ALUOUT;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_mode  = AM_SUB;
                c.pc_source = PCS_ALUOUT;
                c.br_eq     = (op == OP_BEQ);
                c.br_ne     = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_source    = PCS_JUMP;
                c.pc_wr_uncond = 1'b1;
                if (op == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = DST_R31;
                    c.mem_to_reg = WB_PC;
                end
            end
            S_JR: begin
                c.pc_source    = PCS_REGA;
                c.pc_wr_uncond = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.ext_op    = (op == OP_ADDI);
                if (op == OP_ORI)
                    c.alu_mode = AM_OR;
                else if (op == OP_LUI)
                    c.alu_mode = AM_NOP;
            end
            S_I_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = (op == OP_LUI) ? WB_LUI : WB_ALUOUT;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU control decode: maps the FSM's ALU mode and the funct
// field to an ALU operation, flagging functs the datapath cannot execute.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3
) (
    input  alu_mode_t            i_mode,
    input  logic [5:0]           i_funct,
    output logic [ALU_OP_W-1:0]  o_alu_ctrl,
    output logic                 o_bad_funct
);

    logic [2:0] w_code;

    always_comb begin
        w_code      = ALU_ADD;
        o_bad_funct = 1'b0;
        case (i_mode)
            AM_ADD: w_code = ALU_ADD;
            AM_SUB: w_code = ALU_SUB;
            AM_OR:  w_code = ALU_OR;
            AM_NOP: w_code = ALU_NOP;
            AM_FUNCT: begin
                case (i_funct)
                    FN_ADD, FN_ADDU: w_code = ALU_ADD;
                    FN_SUB, FN_SUBU: w_code = ALU_SUB;
                    FN_AND:          w_code = ALU_AND;
                    FN_OR:           w_code = ALU_OR;
                    FN_SLT:          w_code = ALU_SLT;
                    FN_SLTU:         w_code = ALU_SLTU;
                    default: begin
                        w_code      = ALU_NOP;
                        o_bad_funct = 1'b1;
                    end
                endcase
            end
            default: w_code = ALU_ADD;
        endcase
    end

    assign o_alu_ctrl = ALU_OP_W'(w_code);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM with registered per-state control word, memory
// wait-state counter with optional timeout, and illegal-instruction pulse.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          instr_op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          pc_source,
    output logic                ext_op,
    output logic [ALU_OP_W-1:0] alu_ctrl,
    output logic [3:0]          state,
    output logic                illegal
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    ctrl_t            w_ctrl;
    logic             r_illegal;
    logic             w_illegal_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_bad_funct;

    assign w_waiting = ~mem_ready &
                       ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR));
    assign w_timeout = (MEM_TIMEOUT > 0) && w_waiting && (r_wait_cnt == CNT_LAST);

    // Reset drives the FETCH control word straight through so the outputs
    // are defined before the first clock edge has loaded r_ctrl.
    assign w_ctrl = rst ? ctrl_for(S_FETCH, instr_op) : r_ctrl;

    mc_alu_dec #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_dec (
        .i_mode      (w_ctrl.alu_mode),
        .i_funct     (funct),
        .o_alu_ctrl  (alu_ctrl),
        .o_bad_funct (w_bad_funct)
    );

    always_comb begin
        w_next        = r_state;
        w_illegal_nxt = 1'b0;
        w_wait_nxt    = '0;
        if (w_timeout) begin
            w_next        = S_FETCH;
            w_illegal_nxt = 1'b1;
        end else if (w_waiting) begin
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
        end else begin
            case (r_state)
                S_FETCH: w_next = S_DECODE;
                S_DECODE: begin
                    case (instr_op)
                        OP_LW, OP_SW:           w_next = S_MEM_ADDR;
                        OP_RTYPE:               w_next = (funct == FN_JR) ? S_JR : S_R_EXEC;
                        OP_BEQ, OP_BNE:         w_next = S_BRANCH;
                        OP_J, OP_JAL:           w_next = S_JUMP;
                        OP_ADDI, OP_ORI, OP_LUI: w_next = S_I_EXEC;
                        default: begin
                            w_next        = S_FETCH;
                            w_illegal_nxt = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: w_next = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   w_next = S_MEM_WB;
                S_R_EXEC: begin
                    if (w_bad_funct) begin
                        w_next        = S_FETCH;
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_next = S_R_WB;
                    end
                end
                S_I_EXEC: w_next = S_I_WB;
                default:  w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_ctrl     <= ctrl_for(S_FETCH, '0);
            r_illegal  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_ctrl     <= ctrl_for(w_next, instr_op);
            r_illegal  <= w_illegal_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign pc_write   = ~rst & (w_ctrl.pc_wr_uncond |
                                (w_ctrl.pc_wr_fetch & mem_ready) |
                                (w_ctrl.br_eq & zero) |
                                (w_ctrl.br_ne & ~zero));
    assign ir_write   = ~rst & w_ctrl.ir_wr_fetch & mem_ready;
    assign reg_write  = w_ctrl.reg_write;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign iord       = w_ctrl.iord;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign pc_source  = w_ctrl.pc_source;
    assign ext_op     = w_ctrl.ext_op;
    assign state      = rst ? S_FETCH : r_state;
    assign illegal    = ~rst & r_illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level reference model expands each
// instruction into its expected per-cycle output trace, compared on two DUTs.
module tb_mc_ctrl;

    localparam int TMO = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mr, mw, iord, sa;
        logic [1:0] sb, rd, m2r, ps;
        logic       ext;
        logic [2:0] alu;
        logic       ill;
    } obs_t;

    typedef struct {
        obs_t        e;
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mask;
        logic [63:0] tag;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [5:0] instr_op = 6'h00;
    logic [5:0] funct = 6'h20;

    logic       pcw_a, irw_a, rw_a, mr_a, mw_a, iord_a, sa_a, ext_a, ill_a;
    logic [1:0] sb_a, rd_a, m2r_a, ps_a;
    logic [2:0] alu_a;
    logic [3:0] st_a;
    logic       pcw_b, irw_b, rw_b, mr_b, mw_b, iord_b, sa_b, ext_b, ill_b;
    logic [1:0] sb_b, rd_b, m2r_b, ps_b;
    logic [2:0] alu_b;
    logic [3:0] st_b;

    obs_t obs_a, obs_b;
    assign obs_a = {st_a, pcw_a, irw_a, rw_a, mr_a, mw_a, iord_a, sa_a, sb_a, rd_a, m2r_a, ps_a, ext_a, alu_a, ill_a};
    assign obs_b = {st_b, pcw_b, irw_b, rw_b, mr_b, mw_b, iord_b, sa_b, sb_b, rd_b, m2r_b, ps_b, ext_b, alu_b, ill_b};

    mc_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(TMO)) uut_a (
        .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_a), .ir_write(irw_a), .reg_write(rw_a), .mem_read(mr_a), .mem_write(mw_a),
        .iord(iord_a), .alu_src_a(sa_a), .alu_src_b(sb_a), .reg_dst(rd_a), .mem_to_reg(m2r_a),
        .pc_source(ps_a), .ext_op(ext_a), .alu_ctrl(alu_a), .state(st_a), .illegal(ill_a)
    );

    mc_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(0)) uut_b (
        .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_b), .ir_write(irw_b), .reg_write(rw_b), .mem_read(mr_b), .mem_write(mw_b),
        .iord(iord_b), .alu_src_a(sa_b), .alu_src_b(sb_b), .reg_dst(rd_b), .mem_to_reg(m2r_b),
        .pc_source(ps_b), .ext_op(ext_b), .alu_ctrl(alu_b), .state(st_b), .illegal(ill_b)
    );

    always #5 clk = ~clk;

    step_t q[$];
    int    checks = 0;
    int    errors = 0;
    logic  pend = 1'b0;

    logic [5:0] ops[12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h11};
    logic [5:0] fns[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h08, 6'h00, 6'h3C};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic obs_t fetch_obs(input logic rdy);
        obs_t o;
        o = blank(4'd0);
        o.mr  = 1'b1;
        o.sb  = 2'd1;
        o.pcw = rdy;
        o.irw = rdy;
        return o;
    endfunction

    // ALU operation for an R-type funct; ok=0 means the funct is unsupported.
    function automatic logic [2:0] r_alu(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'h20, 6'h21: return 3'd0;
            6'h22, 6'h23: return 3'd1;
            6'h24:        return 3'd2;
            6'h25:        return 3'd3;
            6'h2A:        return 3'd4;
            6'h2B:        return 3'd5;
            default: begin
                ok = 1'b0;
                return 3'd0;
            end
        endcase
    endfunction

    task automatic push(input obs_t e, input logic rdy, input logic z, input logic [5:0] op,
                        input logic [5:0] fn, input logic mask, input logic [63:0] tag);
        step_t s;
        s.e = e; s.rdy = rdy; s.z = z; s.op = op; s.fn = fn; s.mask = mask; s.tag = tag;
        q.push_back(s);
    endtask

    // Expand one instruction into its cycle-by-cycle expected outputs.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm, input logic [63:0] tag);
        obs_t e;
        logic ok;
        logic [2:0] a;
        int nw;
        for (int i = 0; i <= wf; i++) begin
            e = fetch_obs(i == wf);
            e.ill = (i == 0) ? pend : 1'b0;
            push(e, (i == wf), rb(), op, fn, 1'b0, tag);
        end
        pend = 1'b0;
        e = blank(4'd1); e.sb = 2'd3; e.ext = 1'b1;
        push(e, rb(), rb(), op, fn, 1'b0, tag);
        case (op)
            6'h23, 6'h2B: begin
                e = blank(4'd2); e.sa = 1'b1; e.sb = 2'd2; e.ext = 1'b1;
                push(e, rb(), rb(), op, fn, 1'b0, tag);
                if (op == 6'h23) begin
                    for (int i = 0; i <= wm; i++) begin
                        e = blank(4'd3); e.mr = 1'b1; e.iord = 1'b1;
                        push(e, (i == wm), rb(), op, fn, 1'b0, tag);
                    end
                    e = blank(4'd4); e.rw = 1'b1; e.m2r = 2'd1;
                    push(e, rb(), rb(), op, fn, 1'b0, tag);
                end else begin
                    nw = (wm >= TMO) ? TMO : wm + 1;
                    for (int i = 0; i < nw; i++) begin
                        e = blank(4'd5); e.mw = 1'b1; e.iord = 1'b1;
                        push(e, (i == wm), rb(), op, fn, 1'b0, tag);
                    end
                    if (wm >= TMO) pend = 1'b1;
                end
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    e = blank(4'd12); e.ps = 2'd3; e.pcw = 1'b1;
                    push(e, rb(), rb(), op, fn, 1'b0, tag);
                end else begin
                    a = r_alu(fn, ok);
                    e = blank(4'd6); e.sa = 1'b1; e.alu = a;
                    push(e, rb(), rb(), op, fn, ~ok, tag);
                    if (ok) begin
                        e = blank(4'd7); e.rw = 1'b1; e.rd = 2'd1;
                        push(e, rb(), rb(), op, fn, 1'b0, tag);
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
            6'h04, 6'h05: begin
                e = blank(4'd8); e.sa = 1'b1; e.alu = 3'd1; e.ps = 2'd1;
                e.pcw = (op == 6'h04) ? z : ~z;
                push(e, rb(), z, op, fn, 1'b0, tag);
            end
            6'h02, 6'h03: begin
                e = blank(4'd9); e.ps = 2'd2; e.pcw = 1'b1;
                if (op == 6'h03) begin
                    e.rw = 1'b1; e.rd = 2'd2; e.m2r = 2'd2;
                end
                push(e, rb(), rb(), op, fn, 1'b0, tag);
            end
            6'h08, 6'h0D, 6'h0F: begin
                e = blank(4'd10); e.sa = 1'b1; e.sb = 2'd2;
                e.ext = (op == 6'h08);
                e.alu = (op == 6'h08) ? 3'd0 : (op == 6'h0D) ? 3'd3 : 3'd7;
                push(e, rb(), rb(), op, fn, 1'b0, tag);
                e = blank(4'd11); e.rw = 1'b1; e.m2r = (op == 6'h0F) ? 2'd3 : 2'd0;
                push(e, rb(), rb(), op, fn, 1'b0, tag);
            end
            default: pend = 1'b1;
        endcase
    endtask

    task automatic cmp(input obs_t act, input obs_t exp, input logic mask,
                       input logic [63:0] tag, input logic [7:0] who);
        obs_t a;
        obs_t x;
        a = act;
        x = exp;
        if (mask) begin
            a.alu = '0;
            x.alu = '0;
        end
        checks++;
        assert (a === x) else begin
            errors++;
            $error("FAIL %s dut_%s t=%0t observed=%h expected=%h", tag, who, $time, a, x);
        end
    endtask

    task automatic play(input int n, input logic dual);
        step_t s;
        int k;
        k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            s = q.pop_front();
            @(negedge clk);
            instr_op = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
            #1;
            cmp(obs_a, s.e, s.mask, s.tag, "a");
            if (dual) cmp(obs_b, s.e, s.mask, s.tag, "b");
            k++;
        end
    endtask

    // Reset while mem_ready=1: outputs show FETCH values with no PC/IR write.
    task automatic chk_reset(input logic [63:0] tag);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; zero = rb();
        #1;
        cmp(obs_a, fetch_obs(1'b0), 1'b0, tag, "a");
        cmp(obs_b, fetch_obs(1'b0), 1'b0, tag, "b");
        @(posedge clk);
        #1;
        cmp(obs_a, fetch_obs(1'b0), 1'b0, tag, "a");
        cmp(obs_b, fetch_obs(1'b0), 1'b0, tag, "b");
        rst = 1'b0;
        pend = 1'b0;
    endtask

    initial begin
        obs_t e;
        int oi, fi;
        chk_reset("reset");

        build(6'h23, 6'h00, 1'b0, 0, 0, "lw");        play(-1, 1'b1);
        build(6'h05, 6'h00, 1'b1, 0, 0, "bne_z1");    play(-1, 1'b1);
        build(6'h05, 6'h00, 1'b0, 0, 0, "bne_z0");    play(-1, 1'b1);
        build(6'h04, 6'h00, 1'b1, 1, 0, "beq_z1");    play(-1, 1'b1);
        build(6'h03, 6'h00, 1'b0, 0, 0, "jal");       play(-1, 1'b1);
        build(6'h08, 6'h00, 1'b0, 3, 0, "fetchw3");   play(-1, 1'b1);
        build(6'h3F, 6'h00, 1'b0, 0, 0, "op3f");      play(-1, 1'b1);
        build(6'h00, 6'h00, 1'b0, 0, 0, "fn00");      play(-1, 1'b1);
        build(6'h00, 6'h08, 1'b0, 0, 0, "jr");        play(-1, 1'b1);

        build(6'h23, 6'h00, 1'b0, 0, 0, "rst_mrd");   play(3, 1'b1);
        q.delete();
        chk_reset("rst_mrd");

        // Store stalls past the limit: only the timeout-enabled DUT gives up.
        build(6'h2B, 6'h00, 1'b0, 0, TMO, "sw_tmo");  play(-1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            e = fetch_obs(1'b0);
            e.ill = (i == 0);
            cmp(obs_a, e, 1'b0, "tmo_a", "a");
            e = blank(4'd5); e.mw = 1'b1; e.iord = 1'b1;
            cmp(obs_b, e, 1'b0, "tmo_b", "b");
        end
        chk_reset("post_tmo");

        for (int n = 0; n < 80; n++) begin
            oi = $urandom_range(0, 11);
            fi = $urandom_range(0, 10);
            build(ops[oi], fns[fi], rb(), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
            play(-1, 1'b1);
        end
        build(6'h02, 6'h00, 1'b0, 0, 0, "flush");     play(-1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
